// File: rtl/voting_pkg.sv
// rtl/voting_pkg.sv - shared types, constants and helpers for the vote press qualifier
package voting_pkg;

    localparam int NUM_CANDIDATES      = 4;
    localparam int DEFAULT_HOLD_CYCLES = 8;

    typedef logic [1:0] cand_idx_t;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        ARMING       = 2'd1,
        WAIT_RELEASE = 2'd2
    } state_t;

    // Number of buttons currently seen high.
    function automatic logic [2:0] count_ones(input logic [NUM_CANDIDATES-1:0] v);
        count_ones = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    // Index of the highest set bit; only meaningful when exactly one bit is set.
    function automatic cand_idx_t onehot_index(input logic [NUM_CANDIDATES-1:0] v);
        if (v[3])      onehot_index = 2'd3;
        else if (v[2]) onehot_index = 2'd2;
        else if (v[1]) onehot_index = 2'd1;
        else           onehot_index = 2'd0;
    endfunction

    // One-hot mask selecting a single candidate.
    function automatic logic [NUM_CANDIDATES-1:0] cand_mask(input cand_idx_t idx);
        cand_mask = NUM_CANDIDATES'(1) << idx;
    endfunction

endpackage

// File: rtl/vote_press_qualifier_if.sv
// rtl/vote_press_qualifier_if.sv - button/mode inputs and vote/reject/busy outputs of the qualifier
interface vote_press_qualifier_if;

    logic mode;
    logic button1;
    logic button2;
    logic button3;
    logic button4;
    logic vote1;
    logic vote2;
    logic vote3;
    logic vote4;
    logic reject;
    logic busy;

    modport master (
        output mode,
        output button1, button2, button3, button4,
        input  vote1, vote2, vote3, vote4,
        input  reject,
        input  busy
    );

    modport slave (
        input  mode,
        input  button1, button2, button3, button4,
        output vote1, vote2, vote3, vote4,
        output reject,
        output busy
    );

endinterface

// File: rtl/button_sync.sv
// rtl/button_sync.sv - parameterised-width two-flop synchroniser with synchronous reset
module button_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    // Each stage simply takes the value of the stage before it.
    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    // Both stages clear on reset so a held button re-enters as a fresh press.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/vote_press_qualifier.sv
// rtl/vote_press_qualifier.sv - qualifies single-button holds into one vote pulse per press
module vote_press_qualifier
    import voting_pkg::*;
#(
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
    input  logic                   clock,
    input  logic                   reset,
    vote_press_qualifier_if.slave  bus
);

    localparam int                CNT_W   = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic [NUM_CANDIDATES-1:0] raw_buttons;
    logic [NUM_CANDIDATES-1:0] s;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    cand_idx_t                 idx_q, idx_d;
    logic [NUM_CANDIDATES-1:0] vote_q, vote_d;
    logic                      reject_q, reject_d;

    logic [2:0]                n_high;
    logic                      latched_high;
    logic                      others_high;

    assign raw_buttons = {bus.button4, bus.button3, bus.button2, bus.button1};

    button_sync #(
        .WIDTH (NUM_CANDIDATES)
    ) u_button_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (raw_buttons),
        .sync_out (s)
    );

    assign n_high       = count_ones(s);
    assign latched_high = |(s & cand_mask(idx_q));
    assign others_high  = |(s & ~cand_mask(idx_q));

    // Next-state, hold counter and one-cycle vote/reject decisions.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        vote_d   = '0;
        reject_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!bus.mode) begin
                    if (n_high == 3'd1) begin
                        idx_d = onehot_index(s);
                        cnt_d = CNT_ONE;
                        if (CNT_MAX == CNT_ONE) begin
                            vote_d  = cand_mask(onehot_index(s));
                            state_d = WAIT_RELEASE;
                        end else begin
                            state_d = ARMING;
                        end
                    end else if (n_high >= 3'd2) begin
                        reject_d = 1'b1;
                        state_d  = WAIT_RELEASE;
                    end
                end
            end

            ARMING: begin
                if (bus.mode) begin
                    state_d = WAIT_RELEASE;
                end else if (others_high) begin
                    reject_d = 1'b1;
                    state_d  = WAIT_RELEASE;
                end else if (!latched_high) begin
                    state_d = IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_MAX - CNT_ONE) begin
                        vote_d  = cand_mask(idx_q);
                        state_d = WAIT_RELEASE;
                    end
                end
            end

            WAIT_RELEASE: begin
                if (s == '0) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, latched index and registered output pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            vote_q   <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            vote_q   <= vote_d;
            reject_q <= reject_d;
        end
    end

    assign bus.vote1  = vote_q[0];
    assign bus.vote2  = vote_q[1];
    assign bus.vote3  = vote_q[2];
    assign bus.vote4  = vote_q[3];
    assign bus.reject = reject_q;
    assign bus.busy   = (state_q != IDLE);

endmodule
